wb_mem_slave: RTL and testbench
===============================

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: data bus width, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 24: word address bus width.
REQ-003 The block SHALL have parameter DEPTH, default 1024: number of memory words.
REQ-004 The block SHALL have parameter BASE_ADDR, default 24'hA00000: word address of memory word 0.
REQ-005 The block SHALL have parameter WAIT_STATES, default 0, range 0..15: extra cycles inserted before the response.
REQ-006 The block SHALL have these ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- adr_i  input  ADDR_WIDTH  word address.
- dat_i  input  DATA_WIDTH  write data.
- sel_i  input  DATA_WIDTH/8  byte-lane write enables.
- we_i  input  1  1 = write, 0 = read.
- cyc_i  input  1  bus cycle valid.
- stb_i  input  1  transfer strobe.
- ack_o  output  1  normal termination pulse.
- err_o  output  1  error termination pulse (address out of range).
- dat_o  output  DATA_WIDTH  registered read data.
- err_count  output  16  saturating count of error terminations.

Function
REQ-007 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-008 In IDLE, on an edge with cyc_i & stb_i: go to WAIT with the wait counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else go directly to RESP.
REQ-009 In WAIT: decrement the counter each edge; at counter 0 go to RESP on the next edge.
REQ-010 In WAIT, if cyc_i or stb_i is low at an edge, the block SHALL return to IDLE with no response, no write and no counter change (abort).
REQ-011 Entering RESP, the block SHALL sample adr_i, dat_i, sel_i and we_i, and compute offset = adr_i - BASE_ADDR at ADDR_WIDTH bits with unsigned wrap.
REQ-012 Addresses are in range iff adr_i >= BASE_ADDR and offset < DEPTH; addresses below BASE_ADDR SHALL be out of range.
REQ-013 In range, entering RESP: ack_o=1 for exactly one cycle. On a write, only the byte lanes with sel_i set are updated. dat_o SHALL be loaded with the post-write word (write-first).
REQ-014 Out of range, entering RESP: err_o=1 for exactly one cycle, with no memory write, dat_o unchanged, and err_count incremented, saturating at 16'hFFFF.
REQ-015 ack_o and err_o SHALL never be high in the same cycle.
REQ-016 From RESP the block SHALL always return to IDLE on the next edge; a request still asserted is sampled in IDLE as a new transfer.
REQ-017 Latency SHALL be: ack_o/err_o high in the cycle following edge E+WAIT_STATES, where E is the IDLE edge that accepted the request.
REQ-018 Minimum transfer spacing SHALL be WAIT_STATES+2 cycles.
REQ-019 A read with sel_i=0 SHALL still return the full word; a write with sel_i=0 SHALL ack and leave memory unchanged.

Reset
REQ-020 While rst is high, and immediately on its assertion, the block SHALL set: state=IDLE, ack_o=0, err_o=0, dat_o=0, err_count=0, wait counter=0.
REQ-021 Memory contents SHALL NOT be altered by reset.
REQ-022 Reset asserted during WAIT or RESP SHALL drop any pending response and write nothing not yet committed.

Verification
REQ-023 Default parameters: write 16'h1234, sel=2'b11, adr=24'hA00005; then read the same address -> ack one cycle after acceptance; read dat_o=16'h1234.
REQ-024 Byte lanes: word at 0xA00007 = 16'hAAAA; write 16'h5555 with sel=2'b01 -> read returns 16'hAA55.
REQ-025 Out of range: access 24'h9FFFFF, then 24'hA00400 -> err_o each time, no ack_o, err_count=2, and the write to 0xA003FF is unaffected.
REQ-026 WAIT_STATES=3: read accepted at edge E -> ack_o high in the cycle after edge E+3 only; drop stb_i at edge E+2 on a repeat -> no ack, no err.
REQ-027 Async reset mid-WAIT on a write to 0xA00010 (old value 16'h0030) -> outputs zero immediately; later read of 0xA00010 returns 16'h0030.
REQ-028 Back-to-back: stb_i held high for 3 reads with WAIT_STATES=0 -> exactly 3 ack pulses, spaced 2 cycles apart.

Source files
------------

// File: rtl/wb_mem_slave_if.sv
// Wishbone-style classic bus bundle between one master and the memory slave.
// Signal names keep the bus _i/_o suffixes as seen from the slave side.
interface wb_mem_slave_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0]   adr_i;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH/8-1:0] sel_i;
    logic                    we_i;
    logic                    cyc_i;
    logic                    stb_i;
    logic                    ack_o;
    logic                    err_o;
    logic [DATA_WIDTH-1:0]   dat_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        input  ack_o, err_o, dat_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
        output ack_o, err_o, dat_o
    );
endinterface

// File: rtl/wb_mem_slave.sv
// Single-port word memory behind a Wishbone classic slave, with an out-of-range error path.
// ack_o/err_o one cycle after edge E+WAIT_STATES; dropping cyc_i/stb_i during the wait aborts.
module wb_mem_slave #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 24,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 24'hA00000,
    parameter int                    WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    wb_mem_slave_if.slave bus,
    output logic [15:0] err_count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [3:0]            wcnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;

    assign req        = bus.cyc_i & bus.stb_i;
    assign enter_resp = req && (((state == IDLE) && (WAIT_STATES == 0)) ||
                                ((state == WAIT) && (wcnt == 4'd0)));
    // Wrapping subtract: addresses below the base wrap high, so the explicit >= is still required.
    assign offset     = bus.adr_i - BASE_ADDR;
    assign in_range   = (bus.adr_i >= BASE_ADDR) && ({1'b0, offset} < DEPTH_W);
    assign idx        = offset[IDX_W-1:0];
    assign rd_word    = mem[idx];

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (bus.sel_i[b]) begin
                wr_word[b*8 +: 8] = bus.dat_i[b*8 +: 8];
            end
        end
    end

    // No reset on the array; the !rst term keeps a reset edge from committing a write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && in_range && bus.we_i) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wcnt      <= 4'd0;
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;
            bus.dat_o <= '0;
            err_count <= 16'd0;
        end else begin
            bus.ack_o <= 1'b0;
            bus.err_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            wcnt  <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (wcnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                if (in_range) begin
                    bus.ack_o <= 1'b1;
                    bus.dat_o <= bus.we_i ? wr_word : rd_word;
                end else begin
                    bus.err_o <= 1'b1;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: a zero-wait and a three-wait instance share one clock.
module tb_wb_mem_slave;
    logic        clk = 1'b0;
    logic        rst0;
    logic        rst3;
    logic [15:0] errc0;
    logic [15:0] errc3;

    always #5 clk = ~clk;

    wb_mem_slave_if #(.DATA_WIDTH(16), .ADDR_WIDTH(24)) bus0 ();
    wb_mem_slave_if #(.DATA_WIDTH(16), .ADDR_WIDTH(24)) bus3 ();

    wb_mem_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave), .err_count(errc0)
    );
    wb_mem_slave #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave), .err_count(errc3)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    exp_t        e;
    logic [1:0]  r;
    int          acks;
    int          last;
    int          nresp;
    logic [23:0] b2b_adr [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int w, input logic cyc, input logic stb, input logic we,
                         input logic [23:0] adr, input logic [15:0] dat, input logic [1:0] sel);
        if (w == 0) begin
            bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we;
            bus0.adr_i = adr; bus0.dat_i = dat; bus0.sel_i = sel;
        end else begin
            bus3.cyc_i = cyc; bus3.stb_i = stb; bus3.we_i = we;
            bus3.adr_i = adr; bus3.dat_i = dat; bus3.sel_i = sel;
        end
    endtask

    function automatic logic [1:0] resp(input int w);
        return (w == 0) ? {bus0.err_o, bus0.ack_o} : {bus3.err_o, bus3.ack_o};
    endfunction

    function automatic logic [15:0] rdat(input int w);
        return (w == 0) ? bus0.dat_o : bus3.dat_o;
    endfunction

    // One transfer: expectation queued at issue, popped and compared at the response.
    task automatic xfer(input string tag, input int w, input logic we, input logic [23:0] adr,
                        input logic [15:0] dat, input logic [1:0] sel,
                        input logic exp_err, input logic [15:0] exp_dat);
        exp_t       ex;
        logic [1:0] rr;
        int         lat;
        logic       got;
        ex.err = exp_err;
        ex.dat = exp_dat;
        exp_q.push_back(ex);
        @(negedge clk);
        drive(w, 1'b1, 1'b1, we, adr, dat, sel);
        got = 1'b0;
        lat = 0;
        rr  = 2'b00;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            rr = resp(w);
            if (rr != 2'b00) begin
                got = 1'b1;
                lat = i;
            end
        end
        drive(w, 1'b0, 1'b0, 1'b0, adr, dat, sel);
        chk({tag, "_got_resp"}, 32'(got), 32'd1);
        if (got) begin
            ex = exp_q.pop_front();
            chk({tag, "_kind"}, 32'(rr), ex.err ? 32'h2 : 32'h1);
            chk({tag, "_dat"}, 32'(rdat(w)), 32'(ex.dat));
            chk({tag, "_latency"}, 32'(lat), (w == 0) ? 32'd1 : 32'd4);
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        chk({tag, "_single_pulse"}, 32'(resp(w)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        drive(3, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        repeat (2) @(negedge clk);
        chk("rst_ack_err", 32'(resp(0)), 32'd0);
        chk("rst_dat", 32'(bus0.dat_o), 32'd0);
        chk("rst_errcnt", 32'(errc0), 32'd0);
        chk("rst3_dat", 32'(bus3.dat_o), 32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;

        xfer("wr_1234",   0, 1'b1, 24'hA00005, 16'h1234, 2'b11, 1'b0, 16'h1234);
        xfer("rd_1234",   0, 1'b0, 24'hA00005, 16'h0000, 2'b11, 1'b0, 16'h1234);
        xfer("wr_aaaa",   0, 1'b1, 24'hA00007, 16'hAAAA, 2'b11, 1'b0, 16'hAAAA);
        xfer("wr_lane0",  0, 1'b1, 24'hA00007, 16'h5555, 2'b01, 1'b0, 16'hAA55);
        xfer("rd_lanes",  0, 1'b0, 24'hA00007, 16'h0000, 2'b11, 1'b0, 16'hAA55);
        xfer("wr_first",  0, 1'b1, 24'hA00000, 16'h0F0F, 2'b11, 1'b0, 16'h0F0F);
        xfer("wr_last",   0, 1'b1, 24'hA003FF, 16'hBEEF, 2'b11, 1'b0, 16'hBEEF);
        xfer("err_below", 0, 1'b1, 24'h9FFFFF, 16'hDEAD, 2'b11, 1'b1, 16'hBEEF);
        xfer("err_above", 0, 1'b1, 24'hA00400, 16'hDEAD, 2'b11, 1'b1, 16'hBEEF);
        chk("err_count_2", 32'(errc0), 32'd2);
        xfer("rd_last",   0, 1'b0, 24'hA003FF, 16'h0000, 2'b11, 1'b0, 16'hBEEF);
        xfer("rd_first",  0, 1'b0, 24'hA00000, 16'h0000, 2'b11, 1'b0, 16'h0F0F);
        xfer("rd_sel0",   0, 1'b0, 24'hA00005, 16'h0000, 2'b00, 1'b0, 16'h1234);
        xfer("wr_sel0",   0, 1'b1, 24'hA00005, 16'hFFFF, 2'b00, 1'b0, 16'h1234);
        xfer("rd_post_sel0", 0, 1'b0, 24'hA00005, 16'h0000, 2'b11, 1'b0, 16'h1234);

        // Back-to-back reads with the strobe held; the address advances after each ack.
        b2b_adr[0] = 24'hA00005;
        b2b_adr[1] = 24'hA00007;
        b2b_adr[2] = 24'hA003FF;
        e.err = 1'b0; e.dat = 16'h1234; exp_q.push_back(e);
        e.err = 1'b0; e.dat = 16'hAA55; exp_q.push_back(e);
        e.err = 1'b0; e.dat = 16'hBEEF; exp_q.push_back(e);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, b2b_adr[0], 16'h0, 2'b11);
        acks = 0;
        last = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            r = resp(0);
            if (r != 2'b00) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_kind", 32'(r), e.err ? 32'h2 : 32'h1);
                    chk("b2b_dat", 32'(bus0.dat_o), 32'(e.dat));
                end
                if (acks > 0) chk("b2b_spacing", 32'(i - last), 32'd2);
                last = i;
                acks++;
                if (acks < 3) drive(0, 1'b1, 1'b1, 1'b0, b2b_adr[acks], 16'h0, 2'b11);
                else          drive(0, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b11);
            end
        end
        chk("b2b_count", 32'(acks), 32'd3);
        exp_q.delete();

        xfer("ws3_wr", 3, 1'b1, 24'hA00010, 16'h0030, 2'b11, 1'b0, 16'h0030);
        xfer("ws3_rd", 3, 1'b0, 24'hA00010, 16'h0000, 2'b11, 1'b0, 16'h0030);

        // Abort: strobe low at the second edge after acceptance.
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b0, 24'hA00010, 16'h0, 2'b11);
        @(negedge clk);
        nresp = (resp(3) != 2'b00) ? 1 : 0;
        @(negedge clk);
        if (resp(3) != 2'b00) nresp++;
        bus3.stb_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp(3) != 2'b00) nresp++;
        end
        bus3.cyc_i = 1'b0;
        chk("abort_no_resp", 32'(nresp), 32'd0);
        chk("abort_errcnt", 32'(errc3), 32'd0);

        xfer("ws3_err", 3, 1'b0, 24'h000000, 16'h0000, 2'b11, 1'b1, 16'h0030);
        chk("ws3_errcnt_1", 32'(errc3), 32'd1);

        // Reset asserted between edges while a write sits in the wait state.
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b1, 24'hA00010, 16'h1111, 2'b11);
        @(negedge clk);
        #2 rst3 = 1'b1;
        #1;
        chk("arst_dat", 32'(bus3.dat_o), 32'd0);
        chk("arst_errcnt", 32'(errc3), 32'd0);
        chk("arst_resp", 32'(resp(3)), 32'd0);
        drive(3, 1'b0, 1'b0, 1'b0, 24'h0, 16'h0, 2'b00);
        repeat (4) @(negedge clk);
        rst3 = 1'b0;
        xfer("ws3_rd_after_rst", 3, 1'b0, 24'hA00010, 16'h0000, 2'b11, 1'b0, 16'h0030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
